axi_mem_initiator: RTL and testbench
====================================

Name: axi_mem_initiator

Overview:
- AXI master test-traffic generator for the DDR4 path: writes NUM_BURSTS incrementing 512-bit bursts of an address-derived pattern, then reads them back and checks every beat.
- Drives the same AW/W/B/AR/R channel set that the simulation memory target and the MIG slave port accept.
- One transaction in flight at a time. Reports done, error flag and mismatch count.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first burst; must be 64-byte aligned.
- BURST_LEN, 8'd15: AWLEN/ARLEN value. Beats per burst = BURST_LEN+1.
- NUM_BURSTS, 16'd4: number of bursts per pass, range 1..65535.
- TXN_ID, 4'h3: value driven on AWID/WID/ARID; expected on BID/RID.

Ports:
- clk in 1: single clock for all logic.
- reset in 1: asynchronous, active-high.
- start in 1: one-cycle pulse that begins a pass. Ignored while busy.
- busy out 1: high from the cycle after an accepted start until done rises.
- done out 1: set at end of pass; held until the next accepted start.
- error out 1: sticky for the pass; set on any check failure.
- err_count out 16: saturating count of failing checks.
- AWADDR out 32, AWID out 4, AWLEN out 8, AWVALID out 1, AWREADY in 1: write address channel.
- WID out 4, WDATA out 512, WSTRB out 64, WLAST out 1, WVALID out 1, WREADY in 1: write data channel.
- BID in 4, BRESP in 2, BVALID in 1, BREADY out 1: write response channel.
- ARADDR out 32, ARID out 4, ARLEN out 8, ARVALID out 1, ARREADY in 1: read address channel.
- RID in 4, RDATA in 512, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1: read data channel.

Behaviour:
- Reset values: all VALID/READY outputs 0; busy, done, error 0; err_count 0; AWADDR/ARADDR 0; WDATA 0; WLAST 0. Outputs are registered.
- Burst n address = BASE_ADDR + n*(BURST_LEN+1)*64, wrapping modulo 2^32. Beat address increments by 64 per beat.
- Pattern for the beat at address A, 64-bit lane k (0..7, lane 0 in WDATA[63:0]): low 32 bits = A + 8k; high 32 bits = ~(A + 8k).
- WSTRB is all ones. AWID = WID = ARID = TXN_ID.
- FSM states:
  - IDLE: on start → AW; clear error and err_count, clear done, set busy.
  - AW: AWVALID=1 until AWVALID&AWREADY → W. WVALID may rise in the same cycle as the AW handshake, not before.
  - W: WVALID held high; a beat advances on WVALID&WREADY. WLAST=1 exactly on beat BURST_LEN. Handshake with WLAST → B.
  - B: BREADY=1. On BVALID: check BRESP==0 and BID==TXN_ID. Then go to AW for the next burst, or to AR with the burst index reset to 0 after the last burst.
  - AR: ARVALID=1 until handshake → R.
  - R: RREADY=1. On each RVALID&RREADY compare RDATA with the pattern, RRESP==0, RID==TXN_ID, and RLAST==(beat==BURST_LEN). On the last beat → AR for the next burst, or DONE.
  - DONE: done=1, busy=0 → IDLE on the same cycle.
- Each failing check (data, resp, id, last) adds 1 to err_count, saturating at 16'hFFFF, and sets error. Several failures in one beat count separately.
- RLAST early: count one error and treat it as the end of the burst. RLAST missing on the final beat: count one error and end the burst.
- VALID signals are never dropped without a handshake. Address and data are held stable while VALID is high and READY is low.
- start while busy: ignored. start in the same cycle as done: accepted.
- Reset mid-burst: every output returns to its reset value immediately. No partial-burst completion.

Optional Feature:
- Macro AXI_INIT_THROTTLE_EN.
- When defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hB5, advances every clk) gates new assertions. AWVALID, ARVALID and each new WVALID beat start only when lfsr[0]=1. RREADY = lfsr[1] in state R.
- Throttling never drops a VALID that is already high.
- When not defined: no LFSR logic. VALIDs assert immediately and RREADY is constantly 1 in R.

Test Plan:
- Zero-wait slave, BURST_LEN=0, NUM_BURSTS=1, BASE_ADDR=0 → 1 AW, 1 W beat with WLAST=1 and WDATA[63:0]=64'hFFFFFFFF_00000000; 1 AR; done=1, error=0, err_count=0.
- Memory model, BURST_LEN=15, NUM_BURSTS=4 → AWADDR sequence 0x000, 0x400, 0x800, 0xC00; 64 R beats checked; done=1, err_count=0.
- Slave corrupts bit 0 of RDATA on beat 3 of burst 1 → error=1, err_count=1.
- Slave returns BRESP=2'b10 on every burst (NUM_BURSTS=2), data correct → err_count=2. Read phase still runs; done=1.
- Slave asserts RLAST on beat 5 of a 16-beat burst → err_count=1. Next ARADDR issued = previous ARADDR+0x400.
- reset pulsed while in W at beat 7 → AWVALID, WVALID, busy, done all 0 in the same cycle. A new start after release begins again at BASE_ADDR.

Source files
------------

// File: rtl/axi_mem_initiator.sv
// rtl/axi_mem_initiator.sv - AXI write/read-back pattern generator; optional throttling via AXI_INIT_THROTTLE_EN
module axi_mem_initiator #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [7:0]  BURST_LEN  = 8'd15,
    parameter logic [15:0] NUM_BURSTS = 16'd4,
    parameter logic [3:0]  TXN_ID     = 4'h3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  err_count,
    output logic [31:0]  AWADDR,
    output logic [3:0]   AWID,
    output logic [7:0]   AWLEN,
    output logic         AWVALID,
    input  logic         AWREADY,
    output logic [3:0]   WID,
    output logic [511:0] WDATA,
    output logic [63:0]  WSTRB,
    output logic         WLAST,
    output logic         WVALID,
    input  logic         WREADY,
    input  logic [3:0]   BID,
    input  logic [1:0]   BRESP,
    input  logic         BVALID,
    output logic         BREADY,
    output logic [31:0]  ARADDR,
    output logic [3:0]   ARID,
    output logic [7:0]   ARLEN,
    output logic         ARVALID,
    input  logic         ARREADY,
    input  logic [3:0]   RID,
    input  logic [511:0] RDATA,
    input  logic [1:0]   RRESP,
    input  logic         RLAST,
    input  logic         RVALID,
    output logic         RREADY
);

    // Bytes covered by one burst: (BURST_LEN+1) beats of 64 bytes.
    localparam logic [31:0] BURST_BYTES = (32'(BURST_LEN) + 32'd1) << 6;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t        state;
    logic [15:0]   burst_idx;
    logic [7:0]    beat_idx;
    logic [31:0]   burst_addr;
    logic [31:0]   beat_addr;
    logic [511:0]  exp_rdata;
    logic          rlast_exp;
    logic          r_end;
    logic [2:0]    nerr;
    logic [16:0]   err_sum;
    logic [15:0]   err_next;
    logic          last_burst;
    logic [31:0]   next_burst_addr;
    logic          issue_ok;
    logic          rready_gate;

    assign AWID  = TXN_ID;
    assign WID   = TXN_ID;
    assign ARID  = TXN_ID;
    assign AWLEN = BURST_LEN;
    assign ARLEN = BURST_LEN;
    assign WSTRB = {64{1'b1}};

    assign last_burst      = (burst_idx == NUM_BURSTS - 16'd1);
    assign next_burst_addr = burst_addr + BURST_BYTES;

`ifdef AXI_INIT_THROTTLE_EN
    logic [7:0] lfsr;

    // Free-running x^8+x^6+x^5+x^4+1 sequence that paces new VALIDs and RREADY
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr <= 8'hB5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign issue_ok    = lfsr[0];
    assign rready_gate = lfsr[1];
`else
    assign issue_ok    = 1'b1;
    assign rready_gate = 1'b1;
`endif

    // Lane k of a beat at address A carries {~(A+8k), A+8k}
    function automatic logic [511:0] beat_pattern(input logic [31:0] a);
        logic [511:0] p;
        logic [31:0]  w;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            w = a + 32'(8 * k);
            p[64*k +: 64] = {~w, w};
        end
        return p;
    endfunction

    // Per-handshake check results and the saturated error total they produce
    always_comb begin
        exp_rdata = beat_pattern(beat_addr);
        rlast_exp = (beat_idx == BURST_LEN);
        r_end     = RLAST || rlast_exp;
        nerr      = 3'd0;
        if (state == S_B && BVALID && BREADY)
            nerr = 3'(BRESP != 2'b00) + 3'(BID != TXN_ID);
        else if (state == S_R && RVALID && RREADY)
            nerr = 3'(RDATA != exp_rdata) + 3'(RRESP != 2'b00)
                 + 3'(RID != TXN_ID) + 3'(RLAST != rlast_exp);
        err_sum  = {1'b0, err_count} + 17'(nerr);
        err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Pass sequencer: write every burst, then read each back; all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_count  <= 16'd0;
            AWADDR     <= 32'd0;
            AWVALID    <= 1'b0;
            WDATA      <= '0;
            WLAST      <= 1'b0;
            WVALID     <= 1'b0;
            BREADY     <= 1'b0;
            ARADDR     <= 32'd0;
            ARVALID    <= 1'b0;
            RREADY     <= 1'b0;
            burst_idx  <= 16'd0;
            beat_idx   <= 8'd0;
            burst_addr <= 32'd0;
            beat_addr  <= 32'd0;
        end else begin
            if (nerr != 3'd0) begin
                err_count <= err_next;
                error     <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_AW;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_count  <= 16'd0;
                        burst_idx  <= 16'd0;
                        burst_addr <= BASE_ADDR;
                        AWADDR     <= BASE_ADDR;
                        AWVALID    <= issue_ok;
                    end
                end
                S_AW: begin
                    if (!AWVALID) begin
                        AWVALID <= issue_ok;
                    end else if (AWREADY) begin
                        AWVALID   <= 1'b0;
                        state     <= S_W;
                        beat_idx  <= 8'd0;
                        beat_addr <= burst_addr;
                        WDATA     <= beat_pattern(burst_addr);
                        WLAST     <= (BURST_LEN == 8'd0);
                        WVALID    <= issue_ok;
                    end
                end
                S_W: begin
                    if (!WVALID) begin
                        WVALID <= issue_ok;
                    end else if (WREADY) begin
                        if (WLAST) begin
                            WVALID <= 1'b0;
                            WLAST  <= 1'b0;
                            BREADY <= 1'b1;
                            state  <= S_B;
                        end else begin
                            beat_idx  <= beat_idx + 8'd1;
                            beat_addr <= beat_addr + 32'd64;
                            WDATA     <= beat_pattern(beat_addr + 32'd64);
                            WLAST     <= (beat_idx + 8'd1 == BURST_LEN);
                            WVALID    <= issue_ok;
                        end
                    end
                end
                S_B: begin
                    if (BVALID && BREADY) begin
                        BREADY <= 1'b0;
                        if (last_burst) begin
                            burst_idx  <= 16'd0;
                            burst_addr <= BASE_ADDR;
                            ARADDR     <= BASE_ADDR;
                            ARVALID    <= issue_ok;
                            state      <= S_AR;
                        end else begin
                            burst_idx  <= burst_idx + 16'd1;
                            burst_addr <= next_burst_addr;
                            AWADDR     <= next_burst_addr;
                            AWVALID    <= issue_ok;
                            state      <= S_AW;
                        end
                    end
                end
                S_AR: begin
                    if (!ARVALID) begin
                        ARVALID <= issue_ok;
                    end else if (ARREADY) begin
                        ARVALID   <= 1'b0;
                        state     <= S_R;
                        beat_idx  <= 8'd0;
                        beat_addr <= burst_addr;
                        RREADY    <= rready_gate;
                    end
                end
                S_R: begin
                    RREADY <= rready_gate;
                    if (RVALID && RREADY) begin
                        if (r_end) begin
                            // An early or missing RLAST still closes the burst here
                            RREADY <= 1'b0;
                            if (last_burst) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                burst_idx  <= burst_idx + 16'd1;
                                burst_addr <= next_burst_addr;
                                ARADDR     <= next_burst_addr;
                                ARVALID    <= issue_ok;
                                state      <= S_AR;
                            end
                        end else begin
                            beat_idx  <= beat_idx + 8'd1;
                            beat_addr <= beat_addr + 32'd64;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_initiator.sv
// tb/tb_axi_mem_initiator.sv - self-checking bench for axi_mem_initiator
`timescale 1ns/1ps
module tb_axi_mem_initiator;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          NB   = 4;
    localparam int          BL   = 15;
    localparam logic [3:0]  TID  = 4'h3;

    typedef struct {
        int         corrupt_burst;
        int         corrupt_beat;
        int         rresp_burst;
        int         rresp_beat;
        logic [3:0] bresp_mask;
        logic [3:0] bid_mask;
        int         early_burst;
        int         early_beat;
        int         nolast_burst;
        int         stall_pct;
        int         exp_err;
        int         exp_rbeats;
    } scen_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic busy, done, error;
    logic [15:0] err_count;
    logic [31:0] AWADDR; logic [3:0] AWID; logic [7:0] AWLEN; logic AWVALID, AWREADY;
    logic [3:0] WID; logic [511:0] WDATA; logic [63:0] WSTRB; logic WLAST, WVALID, WREADY;
    logic [3:0] BID; logic [1:0] BRESP; logic BVALID, BREADY;
    logic [31:0] ARADDR; logic [3:0] ARID; logic [7:0] ARLEN; logic ARVALID, ARREADY;
    logic [3:0] RID; logic [511:0] RDATA; logic [1:0] RRESP; logic RLAST, RVALID, RREADY;

    logic s_start = 1'b0;
    logic s_busy, s_done, s_error;
    logic [15:0] s_err_count;
    logic [31:0] s_AWADDR; logic [3:0] s_AWID; logic [7:0] s_AWLEN; logic s_AWVALID;
    logic [3:0] s_WID; logic [511:0] s_WDATA; logic [63:0] s_WSTRB; logic s_WLAST, s_WVALID;
    logic s_BREADY;
    logic [31:0] s_ARADDR; logic [3:0] s_ARID; logic [7:0] s_ARLEN; logic s_ARVALID;
    logic s_RREADY;
    logic [511:0] s_RDATA;

    axi_mem_initiator #(.BASE_ADDR(BASE), .BURST_LEN(8'd15), .NUM_BURSTS(16'd4), .TXN_ID(TID)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .err_count(err_count),
        .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    axi_mem_initiator #(.BASE_ADDR(32'h0), .BURST_LEN(8'd0), .NUM_BURSTS(16'd1), .TXN_ID(TID)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done), .error(s_error),
        .err_count(s_err_count),
        .AWADDR(s_AWADDR), .AWID(s_AWID), .AWLEN(s_AWLEN), .AWVALID(s_AWVALID), .AWREADY(1'b1),
        .WID(s_WID), .WDATA(s_WDATA), .WSTRB(s_WSTRB), .WLAST(s_WLAST), .WVALID(s_WVALID), .WREADY(1'b1),
        .BID(TID), .BRESP(2'b00), .BVALID(1'b1), .BREADY(s_BREADY),
        .ARADDR(s_ARADDR), .ARID(s_ARID), .ARLEN(s_ARLEN), .ARVALID(s_ARVALID), .ARREADY(1'b1),
        .RID(TID), .RDATA(s_RDATA), .RRESP(2'b00), .RLAST(1'b1), .RVALID(1'b1), .RREADY(s_RREADY)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cur_scen = -1;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (scenario %0d): got %0h expected %0h", name, cur_scen, got, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [31:0] a);
        logic [511:0] p;
        logic [31:0]  lo;
        p = '0;
        for (int k = 7; k >= 0; k--) begin
            lo = a + 32'(8 * k);
            p = {p[447:0], ~lo, lo};
        end
        return p;
    endfunction

    function automatic void model(input scen_t s, output int errs, output int rbeats);
        int last;
        errs = 0;
        rbeats = 0;
        for (int b = 0; b < NB; b++) begin
            errs += int'(s.bresp_mask[b]) + int'(s.bid_mask[b]);
            last = (s.early_burst == b) ? s.early_beat : BL;
            rbeats += last + 1;
            if (s.corrupt_burst == b && s.corrupt_beat <= last) errs++;
            if (s.rresp_burst == b && s.rresp_beat <= last) errs++;
            if (s.early_burst == b) errs++;
            else if (s.nolast_burst == b) errs++;
        end
    endfunction

    // slave-side memory and progress counters
    scen_t cfg;
    logic [511:0] mem [logic [31:0]];
    int aw_n, w_n, w_burst, w_beat, b_pend, b_n, ar_n, r_beats, r_burst, r_beat;
    logic [31:0] rq [$];
    bit b_retire, r_retire, aw_wait, w_wait, ar_wait;
    logic [31:0] aw_hold, ar_hold, sa;
    logic [511:0] w_hold;

    function automatic bit roll();
        return $urandom_range(99) >= cfg.stall_pct;
    endfunction

    task automatic slave_clear();
        aw_n = 0; w_n = 0; w_burst = 0; w_beat = 0; b_pend = 0; b_n = 0;
        ar_n = 0; r_beats = 0; r_burst = 0; r_beat = 0; rq.delete();
        b_retire = 0; r_retire = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = TID;
        ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0; RID = TID;
    endtask

    // memory slave with random back-pressure and fault injection, driven at negedge
    initial begin
        slave_clear();
        forever begin
            @(negedge clk);
            if (reset) begin
                slave_clear();
                continue;
            end
            if (aw_wait) begin
                chk("aw_valid_held", AWVALID, 1'b1);
                chk("aw_addr_stable", AWADDR, aw_hold);
            end
            AWREADY = roll();
            aw_wait = AWVALID && !AWREADY;
            aw_hold = AWADDR;
            if (AWVALID && AWREADY) begin
                chk("awaddr", AWADDR, BASE + 32'(aw_n * 1024));
                chk("awlen", AWLEN, BL);
                chk("awid", AWID, TID);
                aw_n++;
            end
            if (w_wait) begin
                chk("w_valid_held", WVALID, 1'b1);
                chk("w_data_stable", WDATA, w_hold);
            end
            WREADY = roll();
            w_wait = WVALID && !WREADY;
            w_hold = WDATA;
            if (WVALID && WREADY) begin
                sa = BASE + 32'(w_burst * 1024 + w_beat * 64);
                chk("w_after_aw", w_burst < aw_n, 1'b1);
                chk("wdata", WDATA, pat(sa));
                chk("wlast", WLAST, w_beat == BL);
                chk("wstrb", WSTRB, {64{1'b1}});
                chk("wid", WID, TID);
                mem[sa] = WDATA;
                w_n++;
                if (w_beat == BL) begin
                    w_beat = 0; w_burst++; b_pend++;
                end else begin
                    w_beat++;
                end
            end
            if (b_retire) begin
                BVALID = 0; b_retire = 0;
            end
            if (!BVALID && b_pend > 0 && roll()) begin
                BVALID = 1;
                BRESP = cfg.bresp_mask[b_n[1:0]] ? 2'b10 : 2'b00;
                BID = cfg.bid_mask[b_n[1:0]] ? 4'h5 : TID;
            end
            if (BVALID && BREADY) begin
                b_retire = 1; b_pend--; b_n++;
            end
            if (ar_wait) begin
                chk("ar_valid_held", ARVALID, 1'b1);
                chk("ar_addr_stable", ARADDR, ar_hold);
            end
            ARREADY = roll();
            ar_wait = ARVALID && !ARREADY;
            ar_hold = ARADDR;
            if (ARVALID && ARREADY) begin
                chk("araddr", ARADDR, BASE + 32'(ar_n * 1024));
                chk("arlen", ARLEN, BL);
                chk("arid", ARID, TID);
                chk("ar_after_writes", b_n, NB);
                rq.push_back(ARADDR);
                ar_n++;
            end
            if (r_retire) begin
                RVALID = 0; RLAST = 0; r_retire = 0;
            end
            if (!RVALID && rq.size() > 0 && roll()) begin
                sa = rq[0] + 32'(r_beat * 64);
                RDATA = mem.exists(sa) ? mem[sa] : '0;
                if (r_burst == cfg.corrupt_burst && r_beat == cfg.corrupt_beat) RDATA[0] = ~RDATA[0];
                RRESP = (r_burst == cfg.rresp_burst && r_beat == cfg.rresp_beat) ? 2'b10 : 2'b00;
                RID = TID;
                if (r_burst == cfg.early_burst && r_beat == cfg.early_beat) RLAST = 1;
                else if (r_beat == BL) RLAST = (r_burst != cfg.nolast_burst);
                else RLAST = 0;
                RVALID = 1;
            end
            if (RVALID && RREADY) begin
                r_retire = 1;
                r_beats++;
                if (RLAST || r_beat == BL) begin
                    r_beat = 0; r_burst++; void'(rq.pop_front());
                end else begin
                    r_beat++;
                end
            end
        end
    end

    task automatic run_scen(input scen_t s, input int exp_err, input int exp_rbeats);
        bit got_done;
        @(posedge clk); #1;
        cfg = s;
        slave_clear();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("busy_after_start", busy, 1'b1);
        chk("done_cleared", done, 1'b0);
        chk("first_awaddr", AWADDR, BASE);
        repeat (20) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1;
        start = 0;
        got_done = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if (done) begin
                got_done = 1;
                break;
            end
        end
        chk("done_reached", got_done, 1'b1);
        chk("err_count", err_count, exp_err);
        chk("error_flag", error, exp_err != 0);
        chk("busy_end", busy, 1'b0);
        chk("aw_count", aw_n, NB);
        chk("w_beats", w_n, NB * (BL + 1));
        chk("ar_count", ar_n, NB);
        chk("r_beats", r_beats, exp_rbeats);
        repeat (3) @(posedge clk);
        #1 chk("done_held", done, 1'b1);
    endtask

    scen_t tbl [12];
    scen_t rs;
    int m_err, m_rb, s_aw, s_w, s_ar, cnt;
    logic s_wlast;
    logic [63:0] s_wlo;

    initial begin
        tbl[0]  = '{-1, 0, -1, 0, 4'b0000, 4'b0000, -1, 0, -1,  0, 0, 64};
        tbl[1]  = '{-1, 0, -1, 0, 4'b0000, 4'b0000, -1, 0, -1, 50, 0, 64};
        tbl[2]  = '{ 1, 3, -1, 0, 4'b0000, 4'b0000, -1, 0, -1, 30, 1, 64};
        tbl[3]  = '{-1, 0, -1, 0, 4'b1111, 4'b0000, -1, 0, -1, 20, 4, 64};
        tbl[4]  = '{-1, 0, -1, 0, 4'b0011, 4'b0000, -1, 0, -1,  0, 2, 64};
        tbl[5]  = '{-1, 0, -1, 0, 4'b0000, 4'b0000,  2, 5, -1, 25, 1, 54};
        tbl[6]  = '{-1, 0, -1, 0, 4'b0000, 4'b0000, -1, 0,  3, 10, 1, 64};
        tbl[7]  = '{ 0, 5, -1, 0, 4'b0000, 4'b0000,  0, 5, -1,  0, 2, 54};
        tbl[8]  = '{ 0, 9, -1, 0, 4'b0000, 4'b0000,  0, 5, -1, 40, 1, 54};
        tbl[9]  = '{-1, 0, -1, 0, 4'b0100, 4'b0100, -1, 0, -1, 15, 2, 64};
        tbl[10] = '{ 3, 15, 3, 15, 4'b0000, 4'b0000, -1, 0, -1, 35, 2, 64};
        tbl[11] = '{ 2, 15, -1, 0, 4'b0000, 4'b0000, -1, 0,  2,  5, 2, 64};
        cfg = tbl[0];
        s_RDATA = pat(32'h0);

        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_err_count", err_count, 16'd0);
        chk("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, WLAST}, 6'b0);
        chk("rst_addrs", {AWADDR, ARADDR}, 64'h0);
        chk("rst_wdata", WDATA, 512'h0);
        reset = 0;

        // single-beat pass against an always-ready slave
        @(posedge clk); #1;
        s_start = 1;
        @(posedge clk); #1;
        s_start = 0;
        s_aw = 0; s_w = 0; s_ar = 0; s_wlast = 0; s_wlo = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_done) break;
            if (s_AWVALID) s_aw++;
            if (s_WVALID) begin
                s_w++; s_wlast = s_WLAST; s_wlo = s_WDATA[63:0];
            end
            if (s_ARVALID) s_ar++;
        end
        chk("small_done", s_done, 1'b1);
        chk("small_aw", s_aw, 1);
        chk("small_w", s_w, 1);
        chk("small_wlast", s_wlast, 1'b1);
        chk("small_wdata_lane0", s_wlo, 64'hFFFFFFFF_00000000);
        chk("small_ar", s_ar, 1);
        chk("small_error", s_error, 1'b0);
        chk("small_err_count", s_err_count, 16'd0);

        for (int i = 0; i < 12; i++) begin
            cur_scen = i;
            run_scen(tbl[i], tbl[i].exp_err, tbl[i].exp_rbeats);
        end

        // reset while the first write burst is at beat 7
        cur_scen = 100;
        @(posedge clk); #1;
        cfg = tbl[0];
        slave_clear();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cnt = 0;
        while (w_n < 7 && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("rst_reach_beat7", w_n, 7);
        #2 reset = 1;
        #1;
        chk("midrst_awvalid", AWVALID, 1'b0);
        chk("midrst_wvalid", WVALID, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_wlast", WLAST, 1'b0);
        @(posedge clk); #1;
        reset = 0;
        run_scen(tbl[0], 0, 64);

        for (int i = 0; i < 8; i++) begin
            cur_scen = 200 + i;
            rs.corrupt_burst = int'($urandom_range(4)) - 1;
            rs.corrupt_beat  = int'($urandom_range(15));
            rs.rresp_burst   = int'($urandom_range(4)) - 1;
            rs.rresp_beat    = int'($urandom_range(15));
            rs.bresp_mask    = 4'($urandom_range(15));
            rs.bid_mask      = 4'($urandom_range(15));
            rs.early_burst   = int'($urandom_range(4)) - 1;
            rs.early_beat    = int'($urandom_range(14));
            rs.nolast_burst  = int'($urandom_range(4)) - 1;
            rs.stall_pct     = int'($urandom_range(60));
            model(rs, m_err, m_rb);
            rs.exp_err = m_err;
            rs.exp_rbeats = m_rb;
            run_scen(rs, m_err, m_rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
